// File: rtl/uart_rx_frame_fsm.sv
// UART receive frame controller.
// Finds the start bit on the synchronized serial line, samples WIDTH data bits
// (LSB first) at mid-bit, strobes the downstream stop-bit checker once at the
// stop-bit mid-point, then publishes either a good byte or a framing error.
module uart_rx_frame_fsm #(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_tick,
  input  logic             RX_data,
  input  logic             stop_bit_err,
  output logic             check_stop,
  output logic [WIDTH-1:0] rx_data_out,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WIDTH) + 1;

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_CHK
  } state_t;

  state_t           state_q;
  logic [TW-1:0]    tick_cnt_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] shift_reg_q;
  logic [WIDTH-1:0] rx_data_out_q;
  logic             check_stop_q;
  logic             rx_valid_q;
  logic             frame_err_q;
  logic             busy_q;
  // Cleared after a framing error so a held-low line (break) is not re-read as
  // a new start bit; set again once the line is seen high while idle.
  logic             armed_q;

  assign check_stop  = check_stop_q;
  assign rx_data_out = rx_data_out_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

  // Frame FSM: counters, shift register and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_reg_q   <= '0;
      rx_data_out_q <= '0;
      check_stop_q  <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
      armed_q       <= 1'b1;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      check_stop_q <= 1'b0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (RX_data) begin
            armed_q <= 1'b1;
          end
          if (baud_tick && !RX_data && armed_q) begin
            state_q    <= S_START;
            tick_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end

        S_START: begin
          if (baud_tick) begin
            if (tick_cnt_q == TICK_HALF) begin
              if (RX_data) begin
                // Glitch shorter than half a bit: not a real start bit.
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q    <= S_DATA;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (baud_tick) begin
            if (tick_cnt_q == TICK_LAST) begin
              // Right shift with the new bit at the MSB leaves the first
              // received bit in bit 0 once WIDTH bits are in.
              shift_reg_q <= {RX_data, shift_reg_q[WIDTH-1:1]};
              tick_cnt_q  <= '0;
              bit_cnt_q   <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == BIT_LAST) begin
                state_q <= S_STOP;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end

        S_STOP: begin
          if (baud_tick) begin
            if (tick_cnt_q == TICK_LAST) begin
              check_stop_q <= 1'b1;
              tick_cnt_q   <= '0;
              state_q      <= S_WAIT_CHK;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end

        S_WAIT_CHK: begin
          // The checker answers one clk after seeing check_stop, so the
          // result is taken on the clk after the strobe has dropped.
          if (!check_stop_q) begin
            if (stop_bit_err) begin
              frame_err_q <= 1'b1;
              armed_q     <= 1'b0;
            end else begin
              rx_data_out_q <= shift_reg_q;
              rx_valid_q    <= 1'b1;
            end
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_fsm.sv
// Bench for uart_rx_frame_fsm: serial frames are driven tick-aligned, a stop
// checker is modelled alongside, and every published result is compared with a
// frame-level model (expected byte / expected error per frame sent).
module tb_uart_rx_frame_fsm;

  localparam int WIDTH = 8;
  localparam int OS    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             baud_tick = 1'b0;
  logic             RX_data = 1'b1;
  logic             stop_bit_err;
  logic             check_stop;
  logic [WIDTH-1:0] rx_data_out;
  logic             rx_valid;
  logic             frame_err;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  bit tick_en = 1'b1;
  int tdiv    = 0;

  typedef struct {
    logic       good;
    logic [7:0] d;
    int         lat;
  } ev_t;

  ev_t  act_q[$];
  int   cs_total   = 0;
  int   cs_double  = 0;
  int   both_total = 0;
  int   cyc        = 0;
  int   cs_cyc     = -100;
  logic prev_cs    = 1'b0;

  // Model of the last byte the receiver should be holding.
  logic [7:0] last_good = 8'h00;

  always #5 clk = ~clk;

  uart_rx_frame_fsm #(.WIDTH(WIDTH), .OVERSAMPLE(OS)) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_tick    (baud_tick),
    .RX_data      (RX_data),
    .stop_bit_err (stop_bit_err),
    .check_stop   (check_stop),
    .rx_data_out  (rx_data_out),
    .rx_valid     (rx_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  // Stop checker: samples the line when strobed, answers on the next clk.
  always @(posedge clk or negedge rst) begin
    if (!rst) stop_bit_err <= 1'b0;
    else if (check_stop) stop_bit_err <= !RX_data;
  end

  // baud_tick every 4 clks, pausable.
  initial begin
    forever begin
      @(negedge clk);
      if (tick_en) begin
        tdiv      = (tdiv + 1) % 4;
        baud_tick = (tdiv == 0);
      end else begin
        baud_tick = 1'b0;
      end
    end
  end

  // Output recorder.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (check_stop === 1'b1) begin
        cs_total++;
        if (prev_cs === 1'b1) cs_double++;
        cs_cyc = cyc;
      end
      if (rx_valid === 1'b1 && frame_err === 1'b1) both_total++;
      if (rx_valid === 1'b1 || frame_err === 1'b1)
        act_q.push_back('{rx_valid, rx_data_out, cyc - cs_cyc});
      prev_cs = check_stop;
    end
  end

  task automatic wait_ticks(input int n);
    int guard;
    repeat (n) begin
      guard = 0;
      @(posedge clk);
      while (baud_tick !== 1'b1) begin
        guard++;
        if (guard > 1000) begin
          $display("FAIL wait_ticks: no baud_tick within %0d clks (required 1)", guard);
          failures++;
          $fatal(1, "baud tick generator stalled");
        end
        @(posedge clk);
      end
    end
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop, input int stop_ticks);
    RX_data = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < WIDTH; i++) begin
      RX_data = b[i];
      wait_ticks(OS);
    end
    RX_data = stop;
    wait_ticks(stop_ticks);
    RX_data = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || rx_valid !== 1'b0 || frame_err !== 1'b0 || check_stop !== 1'b0) begin
      $display("FAIL reset_ctrl: busy/valid/ferr/cs=%b%b%b%b required 0000", busy, rx_valid, frame_err, check_stop);
      failures++;
    end
    checks++;
    if (rx_data_out !== 8'h00) begin
      $display("FAIL reset_data: rx_data_out=%h required 00", rx_data_out);
      failures++;
    end
    rst = 1'b1;
    last_good = 8'h00;
    wait_ticks(4);
  endtask

  task automatic test_good_frame();
    ev_t ev;
    int  cs0 = cs_total;
    send_bits(8'hA5, 1'b1, OS);
    wait_ticks(2);
    last_good = 8'hA5;
    checks++;
    if (cs_total - cs0 != 1) begin
      $display("FAIL good_check_stop: pulses=%0d required 1", cs_total - cs0);
      failures++;
    end
    checks++;
    if (act_q.size() != 1) begin
      $display("FAIL good_events: events=%0d required 1", act_q.size());
      failures++;
      act_q.delete();
    end else begin
      ev = act_q.pop_front();
      checks++;
      if (ev.good !== 1'b1 || ev.d !== 8'hA5) begin
        $display("FAIL good_result: valid=%b data=%h required valid=1 data=a5", ev.good, ev.d);
        failures++;
      end
      checks++;
      if (ev.lat != 2) begin
        $display("FAIL good_latency: clks=%0d required 2", ev.lat);
        failures++;
      end
    end
    checks++;
    if (rx_data_out !== 8'hA5 || busy !== 1'b0) begin
      $display("FAIL good_hold: data=%h busy=%b required a5 0", rx_data_out, busy);
      failures++;
    end
  endtask

  task automatic test_false_start();
    int cs0 = cs_total;
    RX_data = 1'b0;
    wait_ticks(3);
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL false_start_busy: busy=%b required 1", busy);
      failures++;
    end
    RX_data = 1'b1;
    wait_ticks(12);
    checks++;
    if (busy !== 1'b0 || cs_total != cs0 || act_q.size() != 0) begin
      $display("FAIL false_start_abort: busy=%b cs=%0d events=%0d required 0 0 0",
               busy, cs_total - cs0, act_q.size());
      failures++;
      act_q.delete();
    end
  endtask

  task automatic test_bad_stop();
    ev_t ev;
    int  cs0 = cs_total;
    send_bits(8'h5A, 1'b0, OS);
    wait_ticks(20);
    checks++;
    if (cs_total - cs0 != 1) begin
      $display("FAIL bad_stop_check_stop: pulses=%0d required 1", cs_total - cs0);
      failures++;
    end
    checks++;
    if (act_q.size() != 1) begin
      $display("FAIL bad_stop_events: events=%0d required 1", act_q.size());
      failures++;
      act_q.delete();
    end else begin
      ev = act_q.pop_front();
      checks++;
      if (ev.good !== 1'b0 || ev.lat != 2) begin
        $display("FAIL bad_stop_result: valid=%b lat=%0d required valid=0 lat=2", ev.good, ev.lat);
        failures++;
      end
    end
    checks++;
    if (rx_data_out !== last_good) begin
      $display("FAIL bad_stop_hold: data=%h required %h", rx_data_out, last_good);
      failures++;
    end
  endtask

  task automatic test_break();
    ev_t ev;
    int  cs0 = cs_total;
    RX_data = 1'b0;
    wait_ticks(OS * 12);
    RX_data = 1'b1;
    wait_ticks(20);
    checks++;
    if (cs_total - cs0 != 1 || act_q.size() != 1) begin
      $display("FAIL break_frames: cs=%0d events=%0d required 1 1", cs_total - cs0, act_q.size());
      failures++;
      act_q.delete();
    end else begin
      ev = act_q.pop_front();
      checks++;
      if (ev.good !== 1'b0 || rx_data_out !== last_good) begin
        $display("FAIL break_result: valid=%b data=%h required valid=0 data=%h", ev.good, rx_data_out, last_good);
        failures++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    ev_t ev;
    int  cs0;
    RX_data = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      RX_data = 1'b1;
      wait_ticks(OS);
    end
    wait_ticks(OS / 2);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rx_valid !== 1'b0 || frame_err !== 1'b0 || check_stop !== 1'b0 || rx_data_out !== 8'h00) begin
      $display("FAIL reset_mid: busy/valid/ferr/cs=%b%b%b%b data=%h required 0000 00",
               busy, rx_valid, frame_err, check_stop, rx_data_out);
      failures++;
    end
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cs0 = cs_total;
    wait_ticks(OS * 6);
    checks++;
    if (cs_total != cs0 || act_q.size() != 0) begin
      $display("FAIL reset_partial: cs=%0d events=%0d required 0 0", cs_total - cs0, act_q.size());
      failures++;
      act_q.delete();
    end
    send_bits(8'h3C, 1'b1, OS);
    wait_ticks(2);
    last_good = 8'h3C;
    checks++;
    if (act_q.size() != 1) begin
      $display("FAIL reset_next_events: events=%0d required 1", act_q.size());
      failures++;
      act_q.delete();
    end else begin
      ev = act_q.pop_front();
      checks++;
      if (ev.good !== 1'b1 || ev.d !== 8'h3C) begin
        $display("FAIL reset_next_data: valid=%b data=%h required 1 3c", ev.good, ev.d);
        failures++;
      end
    end
  endtask

  task automatic test_back_to_back();
    ev_t ev;
    int  cs0 = cs_total;
    logic [7:0] exp_b [2];
    exp_b[0] = 8'h3C;
    exp_b[1] = 8'hC3;
    send_bits(exp_b[0], 1'b1, OS);
    send_bits(exp_b[1], 1'b1, OS);
    wait_ticks(2);
    last_good = exp_b[1];
    checks++;
    if (cs_total - cs0 != 2 || act_q.size() != 2) begin
      $display("FAIL b2b_count: cs=%0d events=%0d required 2 2", cs_total - cs0, act_q.size());
      failures++;
      act_q.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        ev = act_q.pop_front();
        checks++;
        if (ev.good !== 1'b1 || ev.d !== exp_b[k] || ev.lat != 2) begin
          $display("FAIL b2b_frame%0d: valid=%b data=%h lat=%0d required 1 %h 2",
                   k, ev.good, ev.d, ev.lat, exp_b[k]);
          failures++;
        end
      end
    end
  endtask

  task automatic test_tick_pause();
    ev_t ev;
    fork
      send_bits(8'h96, 1'b1, OS);
      begin
        int busy_low = 0;
        int ev0;
        wait_ticks(OS + OS * 3 + 5);
        ev0 = act_q.size();
        tick_en = 1'b0;
        repeat (50) begin
          @(posedge clk);
          #1;
          if (busy !== 1'b1) busy_low++;
        end
        checks++;
        if (busy_low != 0 || act_q.size() != ev0) begin
          $display("FAIL pause_frozen: busy_low_clks=%0d new_events=%0d required 0 0",
                   busy_low, act_q.size() - ev0);
          failures++;
        end
        tick_en = 1'b1;
      end
    join
    wait_ticks(2);
    last_good = 8'h96;
    checks++;
    if (act_q.size() != 1) begin
      $display("FAIL pause_events: events=%0d required 1", act_q.size());
      failures++;
      act_q.delete();
    end else begin
      ev = act_q.pop_front();
      checks++;
      if (ev.good !== 1'b1 || ev.d !== 8'h96) begin
        $display("FAIL pause_data: valid=%b data=%h required 1 96", ev.good, ev.d);
        failures++;
      end
    end
  endtask

  task automatic test_random();
    ev_t        ev;
    logic [7:0] b;
    logic       stop;
    for (int n = 0; n < 12; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_bits(b, stop, OS);
      wait_ticks(2);
      if (stop) last_good = b;
      checks++;
      if (act_q.size() != 1) begin
        $display("FAIL rand%0d_events: events=%0d required 1", n, act_q.size());
        failures++;
        act_q.delete();
      end else begin
        ev = act_q.pop_front();
        checks++;
        if (ev.good !== stop || ev.d !== last_good || ev.lat != 2) begin
          $display("FAIL rand%0d_result: valid=%b data=%h lat=%0d required %b %h 2",
                   n, ev.good, ev.d, ev.lat, stop, last_good);
          failures++;
        end
      end
      wait_ticks($urandom_range(1, 20));
    end
    checks++;
    if (rx_data_out !== last_good) begin
      $display("FAIL rand_hold: data=%h required %h", rx_data_out, last_good);
      failures++;
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_false_start();
    test_bad_stop();
    test_break();
    test_reset_mid_frame();
    test_back_to_back();
    test_tick_pause();
    test_random();
    checks++;
    if (cs_double != 0 || both_total != 0) begin
      $display("FAIL exclusivity: check_stop_runs=%0d valid_and_err=%0d required 0 0", cs_double, both_total);
      failures++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
